// File: rtl/risc_mgmt_mem_arbiter_pkg.sv
// risc_mgmt_arb_pkg: shared types and limits for the RISC-MGMT memory arbiter
package risc_mgmt_arb_pkg;
  typedef enum logic {IDLE, ACTIVE} arb_state_t;
  localparam int MAX_EXT = 8;
endpackage

// File: rtl/risc_mgmt_mem_arbiter_if.sv
// risc_mgmt_mem_arbiter_if: extension-side and core-side memory port signals of the arbiter
interface risc_mgmt_mem_arbiter_if #(parameter int N_EXT = 4);
  logic [N_EXT-1:0] ext_mem_ren, ext_mem_wen, ext_mem_busy, ext_exception;
  logic [N_EXT-1:0][31:0] ext_mem_addr, ext_mem_store;
  logic [N_EXT-1:0][3:0] ext_mem_byte_en;
  logic [31:0] ext_mem_load, core_mem_addr, core_mem_store, core_mem_load;
  logic [3:0] core_mem_byte_en;
  logic core_mem_ren, core_mem_wen, core_mem_busy;
  modport slave (
    input ext_mem_ren, ext_mem_wen, ext_mem_addr, ext_mem_store, ext_mem_byte_en, core_mem_busy, core_mem_load,
    output ext_mem_busy, ext_mem_load, ext_exception, core_mem_ren, core_mem_wen, core_mem_addr, core_mem_store, core_mem_byte_en
  );
  modport master (
    output ext_mem_ren, ext_mem_wen, ext_mem_addr, ext_mem_store, ext_mem_byte_en, core_mem_busy, core_mem_load,
    input ext_mem_busy, ext_mem_load, ext_exception, core_mem_ren, core_mem_wen, core_mem_addr, core_mem_store, core_mem_byte_en
  );
endinterface

// File: rtl/risc_mgmt_mem_arbiter_picker.sv
// rr_priority_picker: combinational round-robin pick of the first requester after last
module rr_priority_picker #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] gnt_idx,
  output logic         any
);
  logic [W-1:0] start, off;
  logic [N-1:0] rot;
  logic [W:0] sum;
  always_comb begin
    start = (last == W'(N-1)) ? '0 : last + W'(1);
    rot = N'({req, req} >> start);
    off = '0;
    for (int i = N-1; i >= 0; i--) if (rot[i]) off = W'(i);
    sum = {1'b0, start} + {1'b0, off};
    gnt_idx = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
  end
  assign any = |req;
endmodule

// File: rtl/risc_mgmt_mem_arbiter.sv
// risc_mgmt_mem_arbiter: round-robin share of the core data-memory port among extensions
// Grant is held until the core completes, the requester flushes, or the timeout fires.
module risc_mgmt_mem_arbiter
  import risc_mgmt_arb_pkg::*;
#(
  parameter int N_EXT = 4,
  parameter int TIMEOUT = 64
) (
  input logic CLK,
  input logic nRST,
  risc_mgmt_mem_arbiter_if.slave bus
);
  localparam int GW = $clog2(N_EXT);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam logic [N_EXT-1:0] ONE = 1;
  if (N_EXT < 2 || N_EXT > MAX_EXT) begin : g_bad_n
    $error("N_EXT out of range");
  end
  arb_state_t state, state_nx;
  logic [GW-1:0] grant, last_grant, pick;
  logic [CW-1:0] cnt;
  logic [N_EXT-1:0] req;
  logic any, active, drive, done, tmo;
  assign req = bus.ext_mem_ren | bus.ext_mem_wen;
  rr_priority_picker #(.N(N_EXT)) u_pick (
    .req(req),
    .last(last_grant),
    .gnt_idx(pick),
    .any(any)
  );
  // A dropped request (flush) removes drive, so the core request falls the same cycle
  always_comb begin
    active = state == ACTIVE;
    drive = active & req[grant];
    done = drive & ~bus.core_mem_busy;
    tmo = (TIMEOUT != 0) & drive & bus.core_mem_busy & (cnt == TLAST);
    state_nx = active ? ((drive & ~tmo & ~done) ? ACTIVE : IDLE) : (any ? ACTIVE : IDLE);
    bus.core_mem_wen = drive & bus.ext_mem_wen[grant];
    bus.core_mem_ren = drive & bus.ext_mem_ren[grant] & ~bus.ext_mem_wen[grant];
    bus.core_mem_addr = drive ? bus.ext_mem_addr[grant] : '0;
    bus.core_mem_store = drive ? bus.ext_mem_store[grant] : '0;
    bus.core_mem_byte_en = drive ? bus.ext_mem_byte_en[grant] : '0;
    bus.ext_mem_busy = req & ~(done ? ONE << grant : '0);
    bus.ext_exception = tmo ? ONE << grant : '0;
  end
  assign bus.ext_mem_load = bus.core_mem_load;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      grant <= '0;
      last_grant <= GW'(N_EXT - 1);
      cnt <= '0;
    end else if (!active) begin
      if (any) begin
        grant <= pick;
        cnt <= '0;
      end
    end else begin
      cnt <= (&cnt) ? cnt : cnt + CW'(1);
      if (state_nx == IDLE) last_grant <= grant;
    end
endmodule

// File: tb/tb_risc_mgmt_mem_arbiter.sv
// tb_risc_mgmt_mem_arbiter: directed scenarios with hand-computed expectations
module tb_risc_mgmt_mem_arbiter;
  logic clk = 1'b0, nrst;
  int vec = 0, errs = 0;
  always #5 clk = ~clk;
  risc_mgmt_mem_arbiter_if #(.N_EXT(4)) bus();
  risc_mgmt_mem_arbiter #(.N_EXT(4), .TIMEOUT(4)) dut (.CLK(clk), .nRST(nrst), .bus(bus));

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.ext_mem_ren = '0;
    bus.ext_mem_wen = '0;
    bus.ext_mem_addr = '0;
    bus.ext_mem_store = '0;
    bus.ext_mem_byte_en = '0;
    bus.core_mem_busy = 1'b0;
    bus.core_mem_load = '0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    clr();
    #1;
    if ({bus.core_mem_ren, bus.core_mem_wen} !== 2'b00) begin errs++; $display("FAIL reset req: got %b want 00", {bus.core_mem_ren, bus.core_mem_wen}); end vec++;
    if (bus.ext_exception !== 4'b0) begin errs++; $display("FAIL reset exc: got %b want 0000", bus.ext_exception); end vec++;
    if (bus.core_mem_addr !== 32'h0) begin errs++; $display("FAIL reset addr: got %h want 0", bus.core_mem_addr); end vec++;
    bus.ext_mem_ren = 4'b0101;
    #1;
    if (bus.ext_mem_busy !== 4'b0101) begin errs++; $display("FAIL reset busy: got %b want 0101", bus.ext_mem_busy); end vec++;
    bus.ext_mem_ren = '0;
    nxt();
    nxt();
    nrst = 1'b1;
    nxt();
  endtask

  task automatic test_fairness();
    logic [3:0] eb;
    clr();
    bus.ext_mem_ren = 4'hF;
    for (int i = 0; i < 4; i++) bus.ext_mem_addr[i] = 32'h1000 + 32'(i * 4);
    for (int k = 0; k < 5; k++) begin
      #4;
      if (bus.core_mem_ren !== 1'b0) begin errs++; $display("FAIL fair idle ren k%0d: got %b want 0", k, bus.core_mem_ren); end vec++;
      if (bus.ext_mem_busy !== 4'hF) begin errs++; $display("FAIL fair idle busy k%0d: got %b want 1111", k, bus.ext_mem_busy); end vec++;
      nxt();
      #4;
      eb = 4'hF & ~(4'b0001 << (k % 4));
      if (bus.core_mem_ren !== 1'b1) begin errs++; $display("FAIL fair ren k%0d: got %b want 1", k, bus.core_mem_ren); end vec++;
      if (bus.core_mem_addr !== 32'h1000 + 32'((k % 4) * 4)) begin errs++; $display("FAIL fair grant k%0d: got addr %h want %h", k, bus.core_mem_addr, 32'h1000 + 32'((k % 4) * 4)); end vec++;
      if (bus.ext_mem_busy !== eb) begin errs++; $display("FAIL fair busy k%0d: got %b want %b", k, bus.ext_mem_busy, eb); end vec++;
      nxt();
    end
    clr();
    nxt();
  endtask

  task automatic test_single();
    logic [3:0] eb;
    clr();
    bus.ext_mem_ren = 4'b0100;
    bus.ext_mem_addr[2] = 32'h100;
    for (int c = 0; c < 5; c++) begin
      bus.core_mem_busy = c < 4;
      bus.core_mem_load = (c == 4) ? 32'hDEADBEEF : 32'h0;
      #4;
      eb = (c < 4) ? 4'b0100 : 4'b0000;
      if (bus.core_mem_ren !== (c >= 1)) begin errs++; $display("FAIL single ren c%0d: got %b want %b", c, bus.core_mem_ren, c >= 1); end vec++;
      if (bus.ext_mem_busy !== eb) begin errs++; $display("FAIL single busy c%0d: got %b want %b", c, bus.ext_mem_busy, eb); end vec++;
      if (bus.ext_exception !== 4'b0) begin errs++; $display("FAIL single exc c%0d: got %b want 0000", c, bus.ext_exception); end vec++;
      if (c >= 1) begin
        if (bus.core_mem_addr !== 32'h100) begin errs++; $display("FAIL single addr c%0d: got %h want 100", c, bus.core_mem_addr); end vec++;
      end
      if (c == 4) begin
        if (bus.ext_mem_load !== 32'hDEADBEEF) begin errs++; $display("FAIL single load: got %h want deadbeef", bus.ext_mem_load); end vec++;
      end
      nxt();
    end
    clr();
    nxt();
  endtask

  task automatic test_write_over_read();
    clr();
    bus.ext_mem_ren = 4'b0010;
    bus.ext_mem_wen = 4'b0010;
    bus.ext_mem_addr[1] = 32'h200;
    bus.ext_mem_store[1] = 32'h12345678;
    bus.ext_mem_byte_en[1] = 4'hF;
    #4;
    if ({bus.core_mem_ren, bus.core_mem_wen} !== 2'b00) begin errs++; $display("FAIL wor idle req: got %b want 00", {bus.core_mem_ren, bus.core_mem_wen}); end vec++;
    if (bus.core_mem_store !== 32'h0 || bus.core_mem_byte_en !== 4'h0) begin errs++; $display("FAIL wor idle data: got %h/%h want 0/0", bus.core_mem_store, bus.core_mem_byte_en); end vec++;
    nxt();
    #4;
    if ({bus.core_mem_ren, bus.core_mem_wen} !== 2'b01) begin errs++; $display("FAIL wor req: got ren,wen=%b want 01", {bus.core_mem_ren, bus.core_mem_wen}); end vec++;
    if (bus.core_mem_store !== 32'h12345678) begin errs++; $display("FAIL wor store: got %h want 12345678", bus.core_mem_store); end vec++;
    if (bus.core_mem_byte_en !== 4'hF || bus.core_mem_addr !== 32'h200) begin errs++; $display("FAIL wor be/addr: got %h/%h want f/200", bus.core_mem_byte_en, bus.core_mem_addr); end vec++;
    if (bus.ext_mem_busy !== 4'b0) begin errs++; $display("FAIL wor busy: got %b want 0000", bus.ext_mem_busy); end vec++;
    nxt();
    clr();
    nxt();
  endtask

  task automatic test_flush();
    clr();
    bus.ext_mem_ren = 4'b0001;
    bus.ext_mem_addr[0] = 32'h300;
    bus.core_mem_busy = 1'b1;
    nxt();
    #4;
    if (bus.core_mem_ren !== 1'b1 || bus.ext_mem_busy !== 4'b0001) begin errs++; $display("FAIL flush active: got ren %b busy %b want 1 0001", bus.core_mem_ren, bus.ext_mem_busy); end vec++;
    nxt();
    bus.ext_mem_ren = 4'b0;
    #4;
    if (bus.core_mem_ren !== 1'b0 || bus.core_mem_addr !== 32'h0) begin errs++; $display("FAIL flush drop: got ren %b addr %h want 0 0", bus.core_mem_ren, bus.core_mem_addr); end vec++;
    if (bus.ext_exception !== 4'b0) begin errs++; $display("FAIL flush exc: got %b want 0000", bus.ext_exception); end vec++;
    nxt();
    bus.ext_mem_ren = 4'b0001;
    bus.core_mem_busy = 1'b0;
    #4;
    if (bus.core_mem_ren !== 1'b0) begin errs++; $display("FAIL flush idle: got ren %b want 0", bus.core_mem_ren); end vec++;
    if (bus.ext_exception !== 4'b0) begin errs++; $display("FAIL flush exc2: got %b want 0000", bus.ext_exception); end vec++;
    nxt();
    #4;
    if (bus.core_mem_ren !== 1'b1 || bus.core_mem_addr !== 32'h300) begin errs++; $display("FAIL flush regrant: got ren %b addr %h want 1 300", bus.core_mem_ren, bus.core_mem_addr); end vec++;
    nxt();
    clr();
    nxt();
  endtask

  task automatic test_async_reset();
    clr();
    bus.ext_mem_ren = 4'b0010;
    bus.ext_mem_addr[1] = 32'h400;
    bus.ext_mem_addr[0] = 32'h500;
    bus.core_mem_busy = 1'b1;
    nxt();
    #4;
    if (bus.core_mem_ren !== 1'b1 || bus.core_mem_addr !== 32'h400) begin errs++; $display("FAIL arst active: got ren %b addr %h want 1 400", bus.core_mem_ren, bus.core_mem_addr); end vec++;
    #1 nrst = 1'b0;
    #1;
    if ({bus.core_mem_ren, bus.core_mem_wen} !== 2'b00) begin errs++; $display("FAIL arst drop: got %b want 00", {bus.core_mem_ren, bus.core_mem_wen}); end vec++;
    if (bus.ext_exception !== 4'b0) begin errs++; $display("FAIL arst exc: got %b want 0000", bus.ext_exception); end vec++;
    bus.ext_mem_ren = 4'b0011;
    #1;
    if (bus.ext_mem_busy !== 4'b0011) begin errs++; $display("FAIL arst busy: got %b want 0011", bus.ext_mem_busy); end vec++;
    nxt();
    nrst = 1'b1;
    #4;
    if (bus.core_mem_ren !== 1'b0) begin errs++; $display("FAIL arst idle: got ren %b want 0", bus.core_mem_ren); end vec++;
    nxt();
    bus.core_mem_busy = 1'b0;
    #4;
    if (bus.core_mem_ren !== 1'b1 || bus.core_mem_addr !== 32'h500) begin errs++; $display("FAIL arst first grant: got ren %b addr %h want 1 500", bus.core_mem_ren, bus.core_mem_addr); end vec++;
    nxt();
    clr();
    nxt();
  endtask

  task automatic test_timeout();
    logic [3:0] ee;
    clr();
    bus.ext_mem_ren = 4'b1100;
    bus.ext_mem_addr[2] = 32'h600;
    bus.ext_mem_addr[3] = 32'h700;
    bus.core_mem_busy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #4;
      ee = (c == 4) ? 4'b0100 : 4'b0000;
      if (bus.core_mem_ren !== (c >= 1 && c <= 4)) begin errs++; $display("FAIL tmo ren c%0d: got %b want %b", c, bus.core_mem_ren, c >= 1 && c <= 4); end vec++;
      if (bus.ext_exception !== ee) begin errs++; $display("FAIL tmo exc c%0d: got %b want %b", c, bus.ext_exception, ee); end vec++;
      if (c >= 1 && c <= 4) begin
        if (bus.core_mem_addr !== 32'h600) begin errs++; $display("FAIL tmo addr c%0d: got %h want 600", c, bus.core_mem_addr); end vec++;
      end
      nxt();
    end
    bus.core_mem_busy = 1'b0;
    #4;
    if (bus.core_mem_ren !== 1'b1 || bus.core_mem_addr !== 32'h700) begin errs++; $display("FAIL tmo next grant: got ren %b addr %h want 1 700", bus.core_mem_ren, bus.core_mem_addr); end vec++;
    if (bus.ext_mem_busy !== 4'b0100) begin errs++; $display("FAIL tmo next busy: got %b want 0100", bus.ext_mem_busy); end vec++;
    if (bus.ext_exception !== 4'b0) begin errs++; $display("FAIL tmo next exc: got %b want 0000", bus.ext_exception); end vec++;
    nxt();
    clr();
    nxt();
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_write_over_read();
    test_flush();
    test_async_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/risc_mgmt_mem_arbiter.md
# risc_mgmt_mem_arbiter

Round-robin arbiter that shares the core's single data-memory port among the memory stages of up to N_EXT RISC-MGMT extensions. It sits between the extension memory-stage outputs (`mem_ren`, `mem_wen`, address, store data, byte enables) and the core memory port. It grants one extension at a time and holds the grant until the core completes that transaction. It stalls losing requesters through per-extension `busy` and aborts with a per-extension exception on timeout.

## Interface
- N_EXT, 4, number of extension requesters (2..8)
- TIMEOUT, 64, cycles a granted transaction may stay busy before abort; 0 disables the timeout
- CLK  in  1  clock; all state updates on the rising edge
- nRST  in  1  asynchronous, active-low reset
- ext_mem_ren  in  N_EXT  per-extension read request
- ext_mem_wen  in  N_EXT  per-extension write request
- ext_mem_addr  in  N_EXT×32  per-extension word address
- ext_mem_store  in  N_EXT×32  per-extension store data
- ext_mem_byte_en  in  N_EXT×4  per-extension byte enables
- ext_mem_busy  out  N_EXT  stall to each extension
- ext_mem_load  out  32  load data, broadcast to all extensions
- ext_exception  out  N_EXT  one-cycle timeout abort pulse
- core_mem_ren  out  1  read request to the core port
- core_mem_wen  out  1  write request to the core port
- core_mem_addr  out  32  address to the core port
- core_mem_store  out  32  store data to the core port
- core_mem_byte_en  out  4  byte enables to the core port
- core_mem_busy  in  1  core port has not yet completed the current request
- core_mem_load  in  32  load data from the core port

## Operation
- req[i] = ext_mem_ren[i] | ext_mem_wen[i]. If ren and wen are both high, the write wins and the read is masked before forwarding.
- FSM states: IDLE and ACTIVE.
- IDLE:
  - If any req is high, register grant = the first requester at or after (last_grant+1) mod N_EXT, clear the timeout counter, and go to ACTIVE.
  - core_mem_ren and core_mem_wen are 0.
- ACTIVE:
  - core_mem_* is muxed combinationally from the granted requester.
  - On core_mem_busy=0, the transaction is done: ext_mem_busy[grant]=0 in that cycle, last_grant<=grant, go to IDLE.
  - Abort, when the granted requester's req drops before done (flush): core request deasserts in the same cycle, go to IDLE, last_grant<=grant, no exception.
  - Timeout, when TIMEOUT≠0 and the counter reaches TIMEOUT-1 while still busy: ext_exception[grant]=1 for that cycle, core request deasserts in the next cycle, go to IDLE, last_grant<=grant.
- ext_mem_busy[i] = req[i] & ~(state==ACTIVE & grant==i & core_mem_busy==0). A non-requesting extension always sees busy=0.
- ext_mem_load = core_mem_load, unregistered.
- When not driving a request, core_mem_addr, core_mem_store and core_mem_byte_en hold 0.
- Timeout counter: $clog2(TIMEOUT+1) bits, saturating, increments every ACTIVE cycle.

## Timing
- Reset: state=IDLE, grant=0, last_grant=N_EXT-1 (ext 0 has first priority), counter=0, core_mem_ren/wen=0, ext_exception=0. ext_mem_busy follows req combinationally even during reset.
- Latency:
  - Request seen in IDLE at cycle 0; core request driven in cycle 1.
  - Earliest completion is cycle 1, when the core returns busy=0 immediately. A single-cycle core therefore gives 2 cycles per transaction.
- Back-to-back transfers have one IDLE bubble between grants.
- Round-robin fairness: with all requesters continuously requesting, the grant order is 0,1,2,…,N_EXT-1,0.
- Simultaneous abort and done in the same cycle counts as done, with busy released.
- Simultaneous timeout and done in the same cycle counts as done, with no exception.
- Reset mid-ACTIVE: the core request drops immediately (asynchronous) and no exception is raised.

## Structure
- Package risc_mgmt_arb_pkg: arb_state_t enum {IDLE, ACTIVE}, and MAX_EXT=8 for the width check.
- Sub-module rr_priority_picker (N parameter): inputs req[N] and last[clog2 N]; outputs gnt_idx and any. Purely combinational rotate/priority/unrotate.
- Top level: FSM, grant/last_grant/counter registers, request mux, busy and exception logic.

## Test plan
- Single requester: ext 2 read, addr 0x100, core busy 3 cycles, load 0xDEADBEEF → core_mem_ren high cycles 1–4; ext_mem_busy[2] high cycles 0–3, low at cycle 4 with ext_mem_load=0xDEADBEEF.
- Fairness: all 4 requesting continuously, core busy=0 → grants 0,1,2,3,0 with 2 cycles each; non-granted busy always high.
- Write-over-read: ext 1 asserts ren=wen=1, store 0x12345678, byte_en 0xF → core_mem_wen=1, core_mem_ren=0, store forwarded.
- Flush abort: ext 0 granted, drops req in cycle 2 while core busy → core_mem_ren low in cycle 2, FSM back in IDLE at cycle 3, ext_exception stays 0.
- Timeout: TIMEOUT=4, core busy held high → ext_exception[grant] single pulse in the 4th ACTIVE cycle, core request low next cycle, next requester granted afterward.
- Async reset asserted mid-ACTIVE → core_mem_ren/wen go 0 without a clock edge; after release, the first grant goes to ext 0.
